// File: rtl/mem_block_mover.sv
// mem_block_mover: memory-port initiator for a 2^AW x DW single-port RAM
// (async read, sync write on M_En). Runs a block COPY (SRC -> DST,
// forward order) or block FILL (FILL_VAL -> DST) without CPU involvement.
//
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   START, MODE         request pulse (sampled in IDLE); 0 = COPY, 1 = FILL
//   SRC, DST, LEN       base addresses and word count (0..2^AW)
//   FILL_VAL            fill constant
//   BUSY, DONE          transfer in progress / one-cycle completion pulse
//   M_ADDR, M_WD, M_En  RAM address, write data, write enable (registered)
//   M_RD                RAM read data (combinational from M_ADDR)
//   CSUM                sum of written words (only with the macro below)
//
// Optional feature: define MEM_BLOCK_MOVER_CHECKSUM_EN to add the CSUM port.
module mem_block_mover #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          MODE,
  input  logic [AW-1:0] SRC,
  input  logic [AW-1:0] DST,
  input  logic [AW:0]   LEN,
  input  logic [DW-1:0] FILL_VAL,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WD,
  output logic          M_En,
  input  logic [DW-1:0] M_RD
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
  ,
  output logic [DW-1:0] CSUM
`endif
);

  typedef enum logic [2:0] {IDLE, RD, WR, FL, FIN} state_t;

  state_t        state;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic [AW:0]   cnt;

  // Pointers wrap naturally at 2^AW.
  logic [AW-1:0] src_inc, dst_inc;
  logic          last;
  assign src_inc = src_ptr + 1'b1;
  assign dst_inc = dst_ptr + 1'b1;
  assign last    = (cnt == {{AW{1'b0}}, 1'b1});

  // All memory-side outputs are registered and loaded for the state being
  // entered, so nothing on the RAM port depends combinationally on inputs.
  // M_WD doubles as the copy data register: RD captures M_RD straight into
  // it, and in FL it simply holds the latched fill constant.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      M_ADDR  <= '0;
      M_WD    <= '0;
      M_En    <= 1'b0;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
      CSUM    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            src_ptr <= SRC;
            dst_ptr <= DST;
            cnt     <= LEN;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
            CSUM    <= '0;
`endif
            if (LEN == '0) begin
              state <= FIN;
              DONE  <= 1'b1;
            end else if (!MODE) begin
              state  <= RD;
              BUSY   <= 1'b1;
              M_ADDR <= SRC;
            end else begin
              state  <= FL;
              BUSY   <= 1'b1;
              M_ADDR <= DST;
              M_WD   <= FILL_VAL;
              M_En   <= 1'b1;
            end
          end
        end

        RD: begin
          state  <= WR;
          M_ADDR <= dst_ptr;
          M_WD   <= M_RD;
          M_En   <= 1'b1;
        end

        WR: begin
          src_ptr <= src_inc;
          dst_ptr <= dst_inc;
          cnt     <= cnt - 1'b1;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
          CSUM    <= CSUM + M_WD;
`endif
          M_En    <= 1'b0;
          M_WD    <= '0;
          if (last) begin
            state  <= FIN;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            M_ADDR <= '0;
          end else begin
            state  <= RD;
            M_ADDR <= src_inc;
          end
        end

        FL: begin
          dst_ptr <= dst_inc;
          cnt     <= cnt - 1'b1;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
          CSUM    <= CSUM + M_WD;
`endif
          if (last) begin
            state  <= FIN;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            M_ADDR <= '0;
            M_WD   <= '0;
            M_En   <= 1'b0;
          end else begin
            M_ADDR <= dst_inc;
          end
        end

        FIN: begin
          // START is deliberately not looked at here.
          state <= IDLE;
          DONE  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          BUSY   <= 1'b0;
          DONE   <= 1'b0;
          M_ADDR <= '0;
          M_WD   <= '0;
          M_En   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Scoreboard bench for mem_block_mover: a reference model of memory pushes the
// expected write stream and completion records into queues; a negedge monitor
// pops and compares whenever the DUT writes or pulses DONE.
module tb_mem_block_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode;
  logic [7:0]  src, dst;
  logic [8:0]  len;
  logic [15:0] fill_val;
  logic        busy, done;
  logic [7:0]  m_addr;
  logic [15:0] m_wd, m_rd;
  logic        m_en;
  logic [15:0] csum;

  always #5 clk = ~clk;

  mem_block_mover dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode),
    .SRC(src), .DST(dst), .LEN(len), .FILL_VAL(fill_val),
    .BUSY(busy), .DONE(done), .M_ADDR(m_addr), .M_WD(m_wd),
    .M_En(m_en), .M_RD(m_rd)
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    , .CSUM(csum)
`endif
  );
`ifndef MEM_BLOCK_MOVER_CHECKSUM_EN
  assign csum = 16'h0;
`endif

  // The RAM the DUT drives, and the reference image it should end up matching.
  logic [15:0] ram [256];
  logic [15:0] mdl [256];
  assign m_rd = ram[m_addr];
  always @(posedge clk) if (m_en) ram[m_addr] <= m_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  typedef struct { int cyc; int busy; logic [15:0] cs; } done_t;
  wr_t   wq[$];
  done_t dq[$];

  int tests = 0, fails = 0;
  int busy_cnt = 0;

  // Monitor
  always @(negedge clk) begin
    wr_t w; done_t e;
    if (m_en) begin
      tests++;
      if (wq.size() == 0) begin
        fails++; $display("FAIL spurious_write: addr=%h data=%h, no write expected", m_addr, m_wd);
      end else begin
        w = wq.pop_front();
        if (m_addr !== w.a || m_wd !== w.d) begin
          fails++; $display("FAIL write: got %h<=%h exp %h<=%h", m_addr, m_wd, w.a, w.d);
        end
      end
    end
    if (done) begin
      tests++;
      if (dq.size() == 0) begin
        fails++; $display("FAIL spurious_done: at cycle %0d, none expected", cyc);
      end else begin
        e = dq.pop_front();
        if (cyc != e.cyc || busy_cnt != e.busy) begin
          fails++; $display("FAIL done_timing: got cyc=%0d busy=%0d exp cyc=%0d busy=%0d", cyc, busy_cnt, e.cyc, e.busy);
        end
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        tests++;
        if (csum !== e.cs) begin
          fails++; $display("FAIL csum: got %h exp %h", csum, e.cs);
        end
`endif
      end
      busy_cnt = 0;
    end
    if (!busy) begin
      tests++;
      if (m_en !== 1'b0 || m_addr !== 8'h0 || m_wd !== 16'h0) begin
        fails++; $display("FAIL idle_outputs: en=%b addr=%h wd=%h exp 0/0/0", m_en, m_addr, m_wd);
      end
    end
    if (!rst_n) busy_cnt = 0;
    else if (busy) busy_cnt++;
  end

  // Reference model: forward word-by-word copy/fill on the memory image,
  // emitting at most nwr writes. Returns the modulo-2^16 sum of data written.
  function automatic logic [15:0] model(input bit md, input int s, input int d,
                                        input int n, input logic [15:0] fv, input int nwr);
    logic [15:0] sum = 16'h0;
    wr_t w;
    for (int i = 0; i < n && i < nwr; i++) begin
      w.a = 8'((d + i) % 256);
      w.d = md ? fv : mdl[(s + i) % 256];
      mdl[w.a] = w.d;
      sum = sum + w.d;
      wq.push_back(w);
    end
    return sum;
  endfunction

  task automatic mem_check(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== mdl[i]) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL mem_%s: %0d words differ, exp 0", name, bad);
    end
  endtask

  task automatic issue(input bit md, input int s, input int d, input int n, input logic [15:0] fv);
    start = 1'b1; mode = md; src = 8'(s); dst = 8'(d); len = 9'(n); fill_val = fv;
  endtask

  // One full transfer; poke holds a conflicting START from mid-transfer until DONE.
  task automatic xfer(input string name, input bit md, input int s, input int d,
                      input int n, input logic [15:0] fv, input bit poke);
    done_t e;
    int lat, k;
    e.cs = model(md, s, d, n, fv, n);
    lat    = (n == 0) ? 1 : (md ? n + 1 : 2 * n + 1);
    e.busy = (n == 0) ? 0 : (md ? n : 2 * n);
    @(posedge clk); #1;
    e.cyc = cyc + lat;
    dq.push_back(e);
    issue(md, s, d, n, fv);
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 issue(~md, $urandom_range(0, 255), $urandom_range(0, 255), 5, 16'h5A5A);
    end
    for (k = 0; k < 2 * n + 20 && (dq.size() != 0 || wq.size() != 0); k++) @(posedge clk);
    #1 start = 1'b0;
    tests++;
    if (dq.size() != 0 || wq.size() != 0) begin
      fails++; $display("FAIL timeout_%s: %0d writes %0d dones pending, exp 0", name, wq.size(), dq.size());
      wq.delete(); dq.delete();
    end
    repeat (3) @(posedge clk);
    mem_check(name);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom); mdl[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || m_en !== 1'b0 || m_addr !== 8'h0 || m_wd !== 16'h0) begin
      fails++; $display("FAIL reset: busy=%b done=%b en=%b addr=%h wd=%h exp all 0", busy, done, m_en, m_addr, m_wd);
    end
    rst_n = 1'b1;

    // Directed cases
    xfer("fill", 1'b1, 0, 8'h10, 4, 16'hA5A5, 1'b0);
    ram[8'h20] = 16'h1111; ram[8'h21] = 16'h2222; ram[8'h22] = 16'h3333;
    mdl[8'h20] = 16'h1111; mdl[8'h21] = 16'h2222; mdl[8'h22] = 16'h3333;
    xfer("copy", 1'b0, 8'h20, 8'h80, 3, 16'hFFFF, 1'b0);
    xfer("wrap", 1'b1, 0, 8'hFE, 3, 16'h0001, 1'b0);
    xfer("len0", 1'b1, 8'h33, 8'h44, 0, 16'h1234, 1'b0);
    xfer("len0c", 1'b0, 8'h33, 8'h44, 0, 16'h1234, 1'b0);
    xfer("len256", 1'b1, 0, 8'h37, 256, 16'hC0DE, 1'b0);
    ram[8'h40] = 16'hBEEF; mdl[8'h40] = 16'hBEEF;
    xfer("overlap", 1'b0, 8'h40, 8'h41, 3, 16'h0, 1'b0);
    xfer("ignore", 1'b0, 8'h60, 8'hA0, 8, 16'h0, 1'b1);
    xfer("copy256", 1'b0, 8'h10, 8'h90, 256, 16'h0, 1'b0);

    // Abort: reset sampled at the edge that would begin the 3rd WR cycle.
    void'(model(1'b0, 8'h08, 8'hC0, 8, 16'h0, 2));
    @(posedge clk); #1;
    c = cyc;
    issue(1'b0, 8'h08, 8'hC0, 8, 16'h0);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || m_en !== 1'b0 || cyc != c + 6) begin
      fails++; $display("FAIL abort: busy=%b en=%b cyc=%0d exp 0/0/%0d", busy, m_en, cyc, c + 6);
    end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (wq.size() != 0) begin
      fails++; $display("FAIL abort_writes: %0d expected writes missing, exp 0", wq.size());
      wq.delete();
    end
    mem_check("abort");
    xfer("after_abort", 1'b1, 0, 8'hC0, 5, 16'h7777, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 30; t++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? 256 : $urandom_range(0, 24);
      xfer("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255),
           n, 16'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Memory-port initiator for the 256x16 single-port data RAM (async read, sync write on En).
- Drives ADDR/WD/En and samples RD to perform block COPY (src to dst) or block FILL (constant) without CPU involvement.
- Sits between the control unit (START/BUSY/DONE) and the RAM port. An external mux grants the port while BUSY or DONE is high.

Parameters:
- AW, 8, address width; RAM depth is 2^AW.
- DW, 16, data word width.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST_N  input  1  synchronous active-low reset.
- START  input  1  request pulse; sampled only in IDLE.
- MODE  input  1  0 = COPY, 1 = FILL; latched on accepted START.
- SRC  input  AW  copy source base address; latched on START.
- DST  input  AW  destination base address; latched on START.
- LEN  input  AW+1  word count, 0..2^AW; latched on START.
- FILL_VAL  input  DW  fill constant; latched on START.
- BUSY  output  1  transfer in progress.
- DONE  output  1  one-cycle completion pulse.
- M_ADDR  output  AW  RAM address.
- M_WD  output  DW  RAM write data.
- M_En  output  1  RAM write enable.
- M_RD  input  DW  RAM read data (combinational from M_ADDR).

Behaviour:
- Reset (RST_N=0 at a rising edge): state=IDLE. BUSY=0, DONE=0, M_En=0, M_ADDR=0, M_WD=0. Counters and data register cleared.
- Reset mid-transfer aborts immediately. No M_En in the cycle after the reset edge. Words already written stay written. No DONE is issued.
- States: IDLE, RD, WR, FL, FIN.
- IDLE:
  - START=1 with LEN!=0 latches all inputs; next state is RD (MODE=0) or FL (MODE=1).
  - START=1 with LEN=0 goes to FIN; no RAM write occurs.
  - START=0 stays in IDLE.
- RD:
  - M_ADDR = src pointer, M_En=0.
  - At the rising edge, M_RD is captured into a DW-bit data register; next state is WR.
- WR:
  - M_ADDR = dst pointer, M_WD = data register, M_En=1.
  - At the edge: both pointers increment, remaining count decrements.
  - Next state is FIN if the remaining count was 1, otherwise RD.
- FL:
  - M_ADDR = dst pointer, M_WD = FILL_VAL, M_En=1.
  - At the edge: dst pointer increments, count decrements.
  - Stays in FL until the last word, then goes to FIN.
- FIN: DONE=1 for exactly one cycle, BUSY=0, M_En=0. Next state is IDLE.
- BUSY=1 in RD, WR and FL; 0 otherwise. BUSY rises in the cycle after the START edge.
- Latency from START edge to DONE high:
  - COPY: 2N+1 cycles.
  - FILL: N+1 cycles.
  - LEN=0: 1 cycle.
- Pointers increment modulo 2^AW, so address 255 wraps to 0. LEN=256 touches every address exactly once per pointer.
- Overlap is defined as forward-copy semantics. If DST lies in (SRC, SRC+LEN), already-written words are re-read, which gives pattern propagation. This is intended, not an error.
- START while BUSY or in FIN is ignored: no latch, no queuing.
- In IDLE and FIN: M_ADDR=0, M_WD=0, M_En=0.
- Memory-side outputs depend only on state and internal registers. There is no combinational path from START, SRC, DST, LEN or MODE.
- Unit width rules: LEN is AW+1 bits. The count register is AW+1 bits and never underflows.

Optional Feature:
- Macro: MEM_BLOCK_MOVER_CHECKSUM_EN.
- Defined:
  - Adds output port CSUM (DW bits): the modulo-2^DW sum of every word written (M_WD when M_En=1) during the current transfer.
  - Cleared to 0 on an accepted START and on reset.
  - Valid and held from the DONE cycle until the next accepted START.
- Undefined: no CSUM port, no adder logic; all other behaviour is identical.

Test Plan:
- Fill: reset, then START with MODE=1, DST=0x10, LEN=4, FILL_VAL=0xA5A5.
  - M_En high for 4 consecutive cycles at 0x10..0x13; DONE at cycle 5 after START.
  - RAM[0x10..0x13]=0xA5A5, RAM[0x14] unchanged. With CHECKSUM_EN, CSUM=0x9694.
- Copy: preload RAM[0x20..0x22]=0x1111, 0x2222, 0x3333; START with MODE=0, SRC=0x20, DST=0x80, LEN=3.
  - Alternating RD/WR cycles; BUSY high for 6 cycles; DONE at cycle 7.
  - RAM[0x80..0x82] matches the source. With CHECKSUM_EN, CSUM=0x6666.
- Wrap and boundaries:
  - Fill DST=0xFE, LEN=3, FILL_VAL=0x0001 writes 0xFE, 0xFF, 0x00.
  - LEN=0 gives DONE one cycle after START with no M_En.
  - LEN=256 fill writes all 256 addresses.
- Overlap: RAM[0x40]=0xBEEF; copy SRC=0x40, DST=0x41, LEN=3.
  - RAM[0x41..0x43] all 0xBEEF (forward propagation).
- Abort and ignore:
  - START asserted during a copy of LEN=8 is ignored; DONE pulses once.
  - Separate run: RST_N=0 on the 3rd WR cycle gives M_En=0 next cycle, BUSY=0, no DONE.
  - Only the first 2 destination words are modified; a new START then works normally.
